speicher_schnittstelle: RTL and testbench

Memory-side responder for the processor control unit's fetch/load/store handshakes. Accepts level-held requests for instruction fetch, data load and data store, runs one transaction at a time on a single-port word memory bus with ready-based variable latency, and returns a one-cycle completion pulse with captured data. Sits between the control unit/datapath and the RAM/ROM bus adapter; a timeout guard keeps the processor from hanging on a dead bus.

---
 rtl/speicher_schnittstelle_pkg.sv | 41 ++++
 rtl/speicher_schnittstelle_zeitueberwachung.sv | 32 +++
 rtl/speicher_schnittstelle.sv | 142 ++++++++++++++
 tb/tb_speicher_schnittstelle.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/speicher_schnittstelle_pkg.sv
// Shared types for the memory-side responder: FSM states, request sources, timeout defaults.
// Request vector bit positions double as the priority order (store > load > fetch).
package speicher_schnittstelle_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LESEN_BEFEHL,
        LESEN_DATEN,
        SCHREIBEN,
        FERTIG,
        FREIGABE
    } zustand_t;

    // Also selects which done pulse fires
    typedef enum logic [1:0] {
        QUELLE_BEFEHL    = 2'd0,
        QUELLE_LADEN     = 2'd1,
        QUELLE_SPEICHERN = 2'd2
    } quelle_t;

    localparam int TIMEOUT_STANDARD = 255;
    localparam int ZAEHLERBREITE    = 8;

    localparam int BIT_BEFEHL    = 0;
    localparam int BIT_LADEN     = 1;
    localparam int BIT_SPEICHERN = 2;

    function automatic quelle_t hoechsteAnforderung(input logic [2:0] anforderung);
        if (anforderung[BIT_SPEICHERN])
            return QUELLE_SPEICHERN;
        else if (anforderung[BIT_LADEN])
            return QUELLE_LADEN;
        else
            return QUELLE_BEFEHL;
    endfunction

    function automatic logic fehlausgerichtet(input logic [1:0] adresseUnten);
        return adresseUnten != 2'b00;
    endfunction

endpackage

// File: rtl/speicher_schnittstelle_zeitueberwachung.sv
// Loadable 8-bit wait counter; abgelaufen flags the last allowed access cycle.
// Counts only while zaehlen is high and stops once the limit is reached.
module zeitueberwachung
    import speicher_schnittstelle_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_STANDARD
) (
    input  logic Clock,
    input  logic Reset,
    input  logic laden,
    input  logic zaehlen,
    output logic abgelaufen
);

    localparam logic [ZAEHLERBREITE-1:0] GRENZE =
        (TIMEOUT > 1) ? ZAEHLERBREITE'(TIMEOUT - 1) : '0;

    logic [ZAEHLERBREITE-1:0] zaehler;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            zaehler <= '0;
        else if (laden)
            zaehler <= '0;
        else if (zaehlen && !abgelaufen)
            zaehler <= zaehler + 1'b1;
    end

    // True during the TIMEOUT-th access cycle, so the abort lands after exactly TIMEOUT bus cycles
    assign abgelaufen = (zaehler == GRENZE);

endmodule

// File: rtl/speicher_schnittstelle.sv
// Fetch/load/store responder: one word transaction at a time, done pulse one cycle after MemBereit.
// Requests are level-held; the bus waits on MemBereit up to TIMEOUT cycles, then aborts with Fehler.
module speicher_schnittstelle
    import speicher_schnittstelle_pkg::*;
#(
    parameter int ADRESSBREITE = 32,
    parameter int DATENBREITE  = 32,
    parameter int TIMEOUT      = TIMEOUT_STANDARD
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    LoadBefehlSignal,
    input  logic                    LoadDatenSignal,
    input  logic                    StoreDatenSignal,
    input  logic [ADRESSBREITE-1:0] Befehlsadresse,
    input  logic [ADRESSBREITE-1:0] Datenadresse,
    input  logic [DATENBREITE-1:0]  StoreDaten,
    output logic                    BefehlGeladen,
    output logic                    DatenGeladen,
    output logic                    DatenGespeichert,
    output logic [DATENBREITE-1:0]  Befehl,
    output logic [DATENBREITE-1:0]  LadeDaten,
    output logic                    Fehler,
    output logic [ADRESSBREITE-1:0] MemAdresse,
    output logic                    MemLesen,
    output logic                    MemSchreiben,
    output logic [DATENBREITE-1:0]  MemDatenAus,
    input  logic [DATENBREITE-1:0]  MemDatenEin,
    input  logic                    MemBereit
);

    zustand_t                zustand, naechsterZustand;
    quelle_t                 quelle, neueQuelle, meldeQuelle;
    logic [2:0]              anforderung;
    logic [ADRESSBREITE-1:0] neueAdresse;
    logic                    neuFehlausgerichtet;
    logic                    annehmen, zugriff, abgelaufen, bedienteAnforderung, meldeFertig;

    always_comb begin
        anforderung                = '0;
        anforderung[BIT_BEFEHL]    = LoadBefehlSignal;
        anforderung[BIT_LADEN]     = LoadDatenSignal;
        anforderung[BIT_SPEICHERN] = StoreDatenSignal;
    end

    zeitueberwachung #(.TIMEOUT(TIMEOUT)) uZeit (
        .Clock      (Clock),
        .Reset      (Reset),
        .laden      (annehmen),
        .zaehlen    (zugriff),
        .abgelaufen (abgelaufen)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            zustand <= IDLE;
        else
            zustand <= naechsterZustand;
    end

    always_comb begin
        naechsterZustand    = zustand;
        annehmen            = 1'b0;
        zugriff             = 1'b0;
        neueQuelle          = hoechsteAnforderung(anforderung);
        neueAdresse         = (neueQuelle == QUELLE_BEFEHL) ? Befehlsadresse : Datenadresse;
        neuFehlausgerichtet = fehlausgerichtet(neueAdresse[1:0]);
        case (quelle)
            QUELLE_LADEN:     bedienteAnforderung = LoadDatenSignal;
            QUELLE_SPEICHERN: bedienteAnforderung = StoreDatenSignal;
            default:          bedienteAnforderung = LoadBefehlSignal;
        endcase
        case (zustand)
            IDLE: begin
                if (|anforderung) begin
                    annehmen = 1'b1;
                    if (neuFehlausgerichtet)
                        naechsterZustand = FERTIG;
                    else if (neueQuelle == QUELLE_SPEICHERN)
                        naechsterZustand = SCHREIBEN;
                    else if (neueQuelle == QUELLE_LADEN)
                        naechsterZustand = LESEN_DATEN;
                    else
                        naechsterZustand = LESEN_BEFEHL;
                end
            end
            LESEN_BEFEHL, LESEN_DATEN, SCHREIBEN: begin
                zugriff = 1'b1;
                if (MemBereit || abgelaufen)
                    naechsterZustand = FERTIG;
            end
            FERTIG:   naechsterZustand = FREIGABE;
            FREIGABE: if (!bedienteAnforderung) naechsterZustand = IDLE;
            default:  naechsterZustand = IDLE;
        endcase
        meldeFertig = (naechsterZustand == FERTIG) && (zustand != FERTIG);
        meldeQuelle = annehmen ? neueQuelle : quelle;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            quelle           <= QUELLE_BEFEHL;
            BefehlGeladen    <= 1'b0;
            DatenGeladen     <= 1'b0;
            DatenGespeichert <= 1'b0;
            Befehl           <= '0;
            LadeDaten        <= '0;
            Fehler           <= 1'b0;
            MemAdresse       <= '0;
            MemLesen         <= 1'b0;
            MemSchreiben     <= 1'b0;
            MemDatenAus      <= '0;
        end else begin
            BefehlGeladen    <= meldeFertig && (meldeQuelle == QUELLE_BEFEHL);
            DatenGeladen     <= meldeFertig && (meldeQuelle == QUELLE_LADEN);
            DatenGespeichert <= meldeFertig && (meldeQuelle == QUELLE_SPEICHERN);
            if (annehmen) begin
                quelle <= neueQuelle;
                if (neuFehlausgerichtet) begin
                    // No bus cycle at all; the requester still gets its done pulse
                    Fehler <= 1'b1;
                    if (neueQuelle == QUELLE_BEFEHL) Befehl    <= '0;
                    if (neueQuelle == QUELLE_LADEN)  LadeDaten <= '0;
                end else begin
                    MemAdresse   <= neueAdresse;
                    MemLesen     <= (neueQuelle != QUELLE_SPEICHERN);
                    MemSchreiben <= (neueQuelle == QUELLE_SPEICHERN);
                    if (neueQuelle == QUELLE_SPEICHERN)
                        MemDatenAus <= StoreDaten;
                end
            end else if (zugriff && (MemBereit || abgelaufen)) begin
                MemLesen     <= 1'b0;
                MemSchreiben <= 1'b0;
                if (!MemBereit)
                    Fehler <= 1'b1;
                if (quelle == QUELLE_BEFEHL) Befehl    <= MemBereit ? MemDatenEin : '0;
                if (quelle == QUELLE_LADEN)  LadeDaten <= MemBereit ? MemDatenEin : '0;
            end
        end
    end

endmodule

// File: tb/tb_speicher_schnittstelle.sv
// Bench for speicher_schnittstelle: transaction-level timeline model plus bench-side word memory.
module tb_speicher_schnittstelle;

    localparam int AB = 32;
    localparam int DB = 32;
    localparam int TO = 255;

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic          LoadBefehlSignal = 1'b0, LoadDatenSignal = 1'b0, StoreDatenSignal = 1'b0;
    logic [AB-1:0] Befehlsadresse = '0, Datenadresse = '0;
    logic [DB-1:0] StoreDaten = '0;
    logic          BefehlGeladen, DatenGeladen, DatenGespeichert;
    logic [DB-1:0] Befehl, LadeDaten;
    logic          Fehler;
    logic [AB-1:0] MemAdresse;
    logic          MemLesen, MemSchreiben;
    logic [DB-1:0] MemDatenAus;
    logic [DB-1:0] MemDatenEin = '0;
    logic          MemBereit = 1'b0;

    always #5 Clock = ~Clock;

    speicher_schnittstelle #(.ADRESSBREITE(AB), .DATENBREITE(DB), .TIMEOUT(TO)) dut (
        .Clock(Clock), .Reset(Reset),
        .LoadBefehlSignal(LoadBefehlSignal), .LoadDatenSignal(LoadDatenSignal),
        .StoreDatenSignal(StoreDatenSignal),
        .Befehlsadresse(Befehlsadresse), .Datenadresse(Datenadresse), .StoreDaten(StoreDaten),
        .BefehlGeladen(BefehlGeladen), .DatenGeladen(DatenGeladen), .DatenGespeichert(DatenGespeichert),
        .Befehl(Befehl), .LadeDaten(LadeDaten), .Fehler(Fehler),
        .MemAdresse(MemAdresse), .MemLesen(MemLesen), .MemSchreiben(MemSchreiben),
        .MemDatenAus(MemDatenAus), .MemDatenEin(MemDatenEin), .MemBereit(MemBereit)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:63];

    bit          modelAktiv = 0;
    bit          expLesen = 0, expSchreiben = 0, expFehler = 0;
    logic [2:0]  expDone = '0;
    logic [31:0] expAdr = '0, expDatAus = '0, expBefehl = '0, expLade = '0;

    int lesenZyklen = 0, schreibZyklen = 0;
    int pulsBefehl = 0, pulsLaden = 0, pulsSpeichern = 0;
    int reihenfolge[$];

    task automatic pruefe(input string name, input logic [31:0] ist, input logic [31:0] soll);
        checks++;
        if (ist !== soll) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, ist, soll, $time);
        end
    endtask

    always @(negedge Clock) begin
        if (modelAktiv) begin
            pruefe("MemLesen", 32'(MemLesen), 32'(expLesen));
            pruefe("MemSchreiben", 32'(MemSchreiben), 32'(expSchreiben));
            pruefe("done", 32'({DatenGespeichert, DatenGeladen, BefehlGeladen}), 32'(expDone));
            pruefe("Fehler", 32'(Fehler), 32'(expFehler));
            pruefe("Befehl", Befehl, expBefehl);
            pruefe("LadeDaten", LadeDaten, expLade);
            if (expLesen || expSchreiben) pruefe("MemAdresse", MemAdresse, expAdr);
            if (expSchreiben) pruefe("MemDatenAus", MemDatenAus, expDatAus);
        end
        if (MemLesen) lesenZyklen++;
        if (MemSchreiben) schreibZyklen++;
        if (BefehlGeladen) begin pulsBefehl++; reihenfolge.push_back(0); end
        if (DatenGeladen) begin pulsLaden++; reihenfolge.push_back(1); end
        if (DatenGespeichert) begin pulsSpeichern++; reihenfolge.push_back(2); end
    end

    task automatic setzeAnf(input int art, input logic v);
        case (art)
            0: LoadBefehlSignal = v;
            1: LoadDatenSignal = v;
            default: StoreDatenSignal = v;
        endcase
    endtask

    task automatic leerlauf(input int c);
        repeat (c) begin
            @(posedge Clock); #1;
            MemBereit = 1'($urandom_range(0, 1));
            MemDatenEin = $urandom;
        end
    endtask

    // Entry: #1 after the edge opening an IDLE cycle. Exit: same point of the next IDLE cycle.
    // maske bits: 0 fetch, 1 load, 2 store. wart = wait cycles before MemBereit (>= TO: never).
    task automatic bediene(input logic [2:0] maske, input logic [31:0] badr, input logic [31:0] dadr,
                           input logic [31:0] sdat, input int wart, input int halte, input bit frueh);
        logic [2:0]  offen;
        logic [31:0] adr, erg;
        int          art, n, d, ende;
        bit          fehl, treffer;
        offen = maske;
        Befehlsadresse = badr; Datenadresse = dadr; StoreDaten = sdat;
        LoadBefehlSignal = maske[0]; LoadDatenSignal = maske[1]; StoreDatenSignal = maske[2];
        while (offen != 3'b000) begin
            art     = offen[2] ? 2 : (offen[1] ? 1 : 0);
            adr     = (art == 0) ? badr : dadr;
            fehl    = (adr[1:0] != 2'b00);
            treffer = !fehl && (wart < TO);
            n       = fehl ? 0 : ((wart >= TO) ? TO : wart + 1);
            d       = frueh ? int'($urandom_range(1, n + 1)) : n + 1 + halte;
            ende    = (n + 3 > d + 1) ? n + 3 : d + 1;
            for (int k = 1; k <= ende; k++) begin
                @(posedge Clock); #1;
                if (k == d) setzeAnf(art, 1'b0);
                if (k <= n) MemBereit = treffer && (k == wart + 1);
                else        MemBereit = 1'($urandom_range(0, 1));
                MemDatenEin  = (MemBereit && k <= n && art != 2) ? mem[adr[7:2]] : $urandom;
                expLesen     = (k <= n) && (art != 2);
                expSchreiben = (k <= n) && (art == 2);
                expAdr       = adr;
                expDatAus    = sdat;
                expDone      = '0;
                if (k == n + 1) begin
                    expDone[art] = 1'b1;
                    if (!treffer) expFehler = 1'b1;
                    erg = treffer ? mem[adr[7:2]] : 32'h0;
                    if (art == 0) expBefehl = erg;
                    if (art == 1) expLade = erg;
                    if (art == 2 && treffer) mem[adr[7:2]] = sdat;
                end
            end
            offen[art] = 1'b0;
        end
    endtask

    task automatic resetPuls();
        modelAktiv = 0;
        LoadBefehlSignal = 0; LoadDatenSignal = 0; StoreDatenSignal = 0; MemBereit = 0;
        #2 Reset = 1'b0;
        expLesen = 0; expSchreiben = 0; expDone = '0;
        expFehler = 0; expBefehl = '0; expLade = '0;
        @(posedge Clock); #1;
        Reset = 1'b1;
        modelAktiv = 1;
    endtask

    function automatic logic [31:0] zufallsAdresse();
        logic [31:0] a;
        a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int l0, s0, p0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;

        #2;
        pruefe("reset_MemLesen", 32'(MemLesen), 32'h0);
        pruefe("reset_MemSchreiben", 32'(MemSchreiben), 32'h0);
        pruefe("reset_done", 32'({DatenGespeichert, DatenGeladen, BefehlGeladen}), 32'h0);
        pruefe("reset_Fehler", 32'(Fehler), 32'h0);
        pruefe("reset_MemAdresse", MemAdresse, 32'h0);
        pruefe("reset_MemDatenAus", MemDatenAus, 32'h0);
        pruefe("reset_Befehl", Befehl, 32'h0);
        pruefe("reset_LadeDaten", LadeDaten, 32'h0);
        @(posedge Clock); #1;
        Reset = 1'b1;
        modelAktiv = 1;
        leerlauf(2);

        // Fetch at 0x10, three wait cycles
        mem[4] = 32'hDEADBEEF;
        l0 = lesenZyklen; p0 = pulsBefehl;
        bediene(3'b001, 32'h10, 32'h0, 32'h0, 3, 0, 0);
        pruefe("fetch_lesezyklen", 32'(lesenZyklen - l0), 32'd4);
        pruefe("fetch_pulse", 32'(pulsBefehl - p0), 32'd1);
        pruefe("fetch_Befehl", Befehl, 32'hDEADBEEF);

        // Store at 0x24, immediate ready, request held long afterwards
        s0 = schreibZyklen; p0 = pulsSpeichern;
        bediene(3'b100, 32'h0, 32'h24, 32'h12345678, 0, 5, 0);
        pruefe("store_schreibzyklen", 32'(schreibZyklen - s0), 32'd1);
        pruefe("store_pulse", 32'(pulsSpeichern - p0), 32'd1);

        // Load and fetch together: load first
        reihenfolge.delete();
        bediene(3'b011, 32'h20, 32'h30, 32'h0, 1, 0, 0);
        pruefe("prio_anzahl", 32'(reihenfolge.size()), 32'd2);
        if (reihenfolge.size() >= 2) begin
            pruefe("prio_erst_laden", 32'(reihenfolge[0]), 32'd1);
            pruefe("prio_dann_befehl", 32'(reihenfolge[1]), 32'd0);
        end

        // Misaligned load
        l0 = lesenZyklen; p0 = pulsLaden;
        bediene(3'b010, 32'h0, 32'h13, 32'h0, 2, 0, 0);
        pruefe("fehl_Fehler", 32'(Fehler), 32'h1);
        pruefe("fehl_LadeDaten", LadeDaten, 32'h0);
        pruefe("fehl_lesezyklen", 32'(lesenZyklen - l0), 32'd0);
        pruefe("fehl_pulse", 32'(pulsLaden - p0), 32'd1);

        // Reset in the middle of a fetch
        modelAktiv = 0;
        LoadBefehlSignal = 1; Befehlsadresse = 32'h40; MemBereit = 0;
        @(posedge Clock); #1;
        pruefe("resetmitte_vorher_MemLesen", 32'(MemLesen), 32'h1);
        p0 = pulsBefehl;
        @(posedge Clock); #3;
        Reset = 1'b0;
        #1;
        pruefe("resetmitte_MemLesen", 32'(MemLesen), 32'h0);
        pruefe("resetmitte_Fehler", 32'(Fehler), 32'h0);
        LoadBefehlSignal = 0;
        @(posedge Clock); #1;
        Reset = 1'b1;
        expLesen = 0; expSchreiben = 0; expDone = '0;
        expFehler = 0; expBefehl = '0; expLade = '0;
        modelAktiv = 1;
        leerlauf(3);
        pruefe("resetmitte_kein_puls", 32'(pulsBefehl - p0), 32'd0);
        mem[16] = 32'hCAFEF00D;
        bediene(3'b001, 32'h40, 32'h0, 32'h0, 2, 1, 0);
        pruefe("resetmitte_neu_Befehl", Befehl, 32'hCAFEF00D);

        // Timeout on a load
        l0 = lesenZyklen; p0 = pulsLaden;
        bediene(3'b010, 32'h0, 32'h50, 32'h0, 300, 0, 0);
        pruefe("timeout_lesezyklen", 32'(lesenZyklen - l0), 32'd255);
        pruefe("timeout_LadeDaten", LadeDaten, 32'h0);
        pruefe("timeout_Fehler", 32'(Fehler), 32'h1);
        pruefe("timeout_pulse", 32'(pulsLaden - p0), 32'd1);

        // Ready arriving in the very last allowed cycle still succeeds
        mem[21] = 32'hA5A55A5A;
        bediene(3'b001, 32'h54, 32'h0, 32'h0, 254, 0, 0);
        pruefe("grenze_Befehl", Befehl, 32'hA5A55A5A);
        pruefe("grenze_Fehler_bleibt", 32'(Fehler), 32'h1);

        // Randomized traffic
        resetPuls();
        for (int t = 0; t < 60; t++) begin
            bediene(3'($urandom_range(1, 7)), zufallsAdresse(), zufallsAdresse(), $urandom,
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0));
            leerlauf(int'($urandom_range(0, 2)));
        end
        leerlauf(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
